// File: rtl/product_bcd_converter_pkg.sv
// Shared types and sizing for the multiplier -> BCD -> display datapath.
package product_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PROD_WIDTH  = 16;
  localparam int BCD_DIGITS  = 5;
  localparam int DIGIT_WIDTH = 4;

endpackage

// File: rtl/product_bcd_converter_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import product_bcd_converter_pkg::*;
(
  input  logic [DIGIT_WIDTH-1:0] digit,
  output logic [DIGIT_WIDTH-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// One conversion takes WIDTH shift cycles; bcd holds until the next completion.
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = PROD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin,
  output logic                         busy,
  output logic                         done,
  output logic [DIGIT_WIDTH*DIGITS-1:0] bcd
);

  localparam int BCD_W = DIGIT_WIDTH * DIGITS;
  localparam int REG_W = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [REG_W-1:0] work;
  logic [REG_W-1:0] adj_work;
  logic [REG_W-1:0] shifted;

  assign adj_work[WIDTH-1:0] = work[WIDTH-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (work[WIDTH + DIGIT_WIDTH*i +: DIGIT_WIDTH]),
      .adjusted (adj_work[WIDTH + DIGIT_WIDTH*i +: DIGIT_WIDTH])
    );
  end

  // The DIGITS constraint guarantees the bit shifted out of the top is always zero.
  assign shifted = adj_work << 1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      work  <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= {{BCD_W{1'b0}}, bin};
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            bcd   <= shifted[REG_W-1 -: BCD_W];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter against a decimal-arithmetic reference.
module tb_product_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_bcd = '0;

  product_bcd_converter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    int div = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  // Assumes DUT is IDLE and we are #1 after an edge. Optionally pulses start
  // with bin=777 after shift number inject_at; that request must be ignored.
  task automatic run_conv(input logic [15:0] v, input int inject_at);
    logic [19:0] prev = exp_bcd;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = $urandom_range(0, 65535);
    chk("busy_accept", busy, 1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk("busy_run", busy, 1);
      chk("done_run", done, (i == 16));
      chk("bcd_run", bcd, (i == 16) ? to_bcd(v) : prev);
      if (i == inject_at) begin
        start = 1'b1;
        bin   = 16'd777;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp_bcd = to_bcd(v);
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
    chk("bcd_idle", bcd, exp_bcd);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_conv(16'd0, 0);
    run_conv(16'd65535, 0);
    run_conv(16'd65025, 0);
    run_conv(16'd1234, 0);
    run_conv(16'd9, 0);

    // Start request during SHIFT must be dropped entirely
    run_conv(16'd42, 5);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_second_done", done, 0);
      chk("no_second_busy", busy, 0);
    end

    // Asynchronous reset mid-conversion
    start = 1'b1;
    bin   = 16'd500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_bcd", bcd, 0);
    exp_bcd = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_conv(16'd500, 0);

    // Random values
    for (int n = 0; n < 12; n++) begin
      run_conv(16'($urandom_range(0, 65535)), 0);
    end

    // start held high: accept every 18 cycles
    start = 1'b1;
    bin   = 16'd100;
    @(posedge clk); #1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      chk("hold_done", done, (n >= 16) && ((n - 16) % 18 == 0));
      if (n >= 16) chk("hold_bcd", bcd, to_bcd(100));
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Sequential binary-to-BCD converter (shift-add-3, "double dabble") sitting directly downstream of the 8x8 shift-add multiplier.
- Takes the 16-bit product and produces 5 packed BCD digits for the decimal display stage.
- Start/busy/done handshake. One conversion at a time, fixed latency of WIDTH shift cycles.

Parameters:
- WIDTH, 16, binary input width; matches the multiplier product width.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-high; one clock domain only.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  binary value (multiplier product); sampled on the accepting edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when bcd is updated.
- bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, internal shift register=0, bcd=0, done=0, busy=0. Takes effect immediately, mid-conversion included; the partial result is discarded and bcd reads 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On a rising edge with start=1: capture bin into the low WIDTH bits of the working register (BCD field cleared), set count=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - For every BCD digit in the working register, if digit >= 5 add 3 (4-bit, no carry out of the digit).
  - Shift the whole {bcd_field, bin_field} register left by 1.
  - Increment count.
  - On the edge that performs shift number WIDTH (count = WIDTH-1 before the edge): copy the resulting BCD field to bcd and go to DONE.
- DONE: done=1 for exactly this cycle. Next edge goes to IDLE unconditionally.
- Timing: with start accepted at edge k, bcd is valid and done=1 after edge k+WIDTH (16). IDLE is re-entered at edge k+WIDTH+1. The earliest next accepted start is edge k+WIDTH+2.
- Control rules:
  - start is ignored in SHIFT and DONE. It is neither queued nor treated as an error.
  - bin changes after the accepting edge have no effect.
  - bcd holds its last value until the next DONE, including while a new conversion runs. It is not cleared at start.
- Output timing: busy is combinational from state. done and bcd are registered.
- Width rules: working register is 4*DIGITS + WIDTH bits. count is ceil(log2(WIDTH+1)) bits. No overflow is possible given the DIGITS constraint.

Decomposition:
- Shared package:
  - State enum (IDLE, SHIFT, DONE).
  - Constants PROD_WIDTH=16 and BCD_DIGITS=5, also used by the multiplier and display blocks.
  - BCD digit width constant of 4.
- One natural sub-module: bcd_digit_adjust. Combinational, 4-bit in and 4-bit out, adds 3 when the input is >= 5. Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset then start with bin=0 -> done pulse 16 cycles after the accepting edge; bcd=0x00000; busy high for 17 cycles.
- bin=65535 -> bcd=0x65535. bin=65025 (255*255, maximum multiplier product) -> bcd=0x65025.
- bin=1234, then after done, bin=9 -> bcd=0x01234, then 0x00009; bcd stays 0x01234 throughout the second conversion until its done.
- start pulsed with bin=777 at cycle 5 of a conversion of bin=42 -> result 0x00042 only; no second done; busy falls after DONE.
- Assert rst asynchronously between clock edges at shift 8 of bin=500 -> busy, done and bcd go to 0 immediately. A later start with bin=500 -> bcd=0x00500.
- start held high continuously with bin=100 -> conversions accepted every 18 cycles; done pulses spaced 18 cycles apart; each gives bcd=0x00100.
